// File: rtl/aes_ctrl_if.sv
// Byte-stream bus for aes_ctrl: command/data bytes in (s_*), result bytes out (m_*).
// The master drives bytes in and consumes results; the slave is the controller.
`timescale 1ns/1ps
interface aes_ctrl_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid);
    modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
endinterface

// File: rtl/aes_ctrl.sv
// Byte-serial command front end for an AES core: key/block reception, start/wait, result streaming.
// Optional macro AES_CTRL_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES cycles from aes_start_o.
`timescale 1ns/1ps
module aes_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    aes_ctrl_if.slave    strm,
    output logic [127:0] aes_key_o,
    output logic         aes_key_load_o,
    output logic [127:0] aes_block_o,
    output logic         aes_start_o,
    input  logic         aes_done_i,
    input  logic [127:0] aes_result_i,
    output logic         key_valid_o,
    output logic         busy_o,
    output logic         err_o
);
    typedef enum logic [2:0] {IDLE, RX_KEY, KEY_LOAD, RX_BLK, START, WAIT, TX} state_e;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("aes_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [119:0] shreg_q;
    logic [127:0] shreg_d;
    logic [127:0] key_q, blk_q, res_q;
    logic         key_valid_q, err_q, key_load_q, start_q;
    logic         s_fire, m_fire, last_byte, tmo_hit;

    assign shreg_d   = {shreg_q, strm.s_data};
    assign last_byte = (cnt_q == 4'hf);

    // rst_n is active-high here: hold s_ready low for the whole reset window.
    assign strm.s_ready = !rst_n &&
                          (state_q == IDLE || state_q == RX_KEY || state_q == RX_BLK);
    assign s_fire       = strm.s_valid && strm.s_ready;
    assign strm.m_valid = (state_q == TX);
    assign strm.m_data  = res_q[127:120];
    assign m_fire       = strm.m_valid && strm.m_ready;

    assign aes_key_o      = key_q;
    assign aes_block_o    = blk_q;
    assign aes_key_load_o = key_load_q;
    assign aes_start_o    = start_q;
    assign key_valid_o    = key_valid_q;
    assign err_o          = err_q;
    assign busy_o         = (state_q != IDLE);

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;
    // Counts from the start strobe cycle, so the hit lands TIMEOUT_CYCLES edges after it.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            tmo_q <= '0;
        else if (state_q == START || state_q == WAIT)
            tmo_q <= tmo_q + TW'(1);
        else
            tmo_q <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            key_q       <= '0;
            blk_q       <= '0;
            res_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            key_load_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            key_load_q <= 1'b0;
            start_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_fire) begin
                        case (strm.s_data)
                            8'h00:   err_q   <= 1'b0;
                            8'h01:   state_q <= RX_KEY;
                            8'h02:   state_q <= RX_BLK;
                            default: err_q   <= 1'b1;
                        endcase
                    end
                end
                RX_KEY, RX_BLK: begin
                    if (s_fire) begin
                        shreg_q <= shreg_d[119:0];
                        cnt_q   <= cnt_q + 4'd1;
                        if (last_byte) begin
                            if (state_q == RX_KEY) begin
                                key_q       <= shreg_d;
                                key_load_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                                state_q     <= KEY_LOAD;
                            end else if (key_valid_q) begin
                                blk_q   <= shreg_d;
                                start_q <= 1'b1;
                                state_q <= START;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                KEY_LOAD: state_q <= IDLE;
                START:    state_q <= WAIT;
                WAIT: begin
                    if (aes_done_i) begin
                        res_q   <= aes_result_i;
                        state_q <= TX;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                TX: begin
                    // Result shifts out MSB-first; fully drained it reads back as zero.
                    if (m_fire) begin
                        res_q <= {res_q[119:0], 8'h00};
                        cnt_q <= cnt_q + 4'd1;
                        if (last_byte)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes_ctrl.md
AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the max cycles waited for aes_done_i after aes_start_o.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_data  input  8  command/data byte in.
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  byte accepted when s_valid&s_ready at clk edge.
REQ-007 SHALL have port m_data  output  8  result byte out.
REQ-008 SHALL have port m_valid  output  1  m_data valid.
REQ-009 SHALL have port m_ready  input  1  byte consumed when m_valid&m_ready at clk edge.
REQ-010 SHALL have port aes_key_o  output  128  key to AES core.
REQ-011 SHALL have port aes_key_load_o  output  1  one-cycle key-load strobe.
REQ-012 SHALL have port aes_block_o  output  128  plaintext to AES core.
REQ-013 SHALL have port aes_start_o  output  1  one-cycle encrypt-start strobe.
REQ-014 SHALL have port aes_done_i  input  1  one-cycle completion strobe from core.
REQ-015 SHALL have port aes_result_i  input  128  ciphertext, valid while aes_done_i=1.
REQ-016 SHALL have ports key_valid_o, busy_o, err_o  output  1 each  key loaded / FSM not IDLE / sticky error.

Function
REQ-017 SHALL implement states IDLE, RX_KEY, KEY_LOAD, RX_BLK, START, WAIT, TX.
REQ-018 IDLE SHALL assert s_ready and take one opcode byte: 0x00 clears err_o (stay IDLE); 0x01 -> RX_KEY; 0x02 -> RX_BLK; any other sets err_o, stays IDLE.
REQ-019 RX_KEY/RX_BLK SHALL assert s_ready and accept exactly 16 bytes via 4-bit counter; first byte lands in bits [127:120], last in [7:0].
REQ-020 After the 16th key byte, SHALL go to KEY_LOAD, pulse aes_key_load_o for exactly one cycle, set key_valid_o, return to IDLE.
REQ-021 After the 16th block byte with key_valid_o=1, SHALL go to START, pulse aes_start_o one cycle, then enter WAIT.
REQ-022 After the 16th block byte with key_valid_o=0, SHALL set err_o, discard the block, return to IDLE without aes_start_o.
REQ-023 In WAIT, on aes_done_i=1 SHALL latch aes_result_i in the same edge and enter TX.
REQ-024 TX SHALL present result bytes MSB-first (first m_data = result[127:120]), advancing only on m_valid&m_ready, m_data stable while stalled; after 16th handshake -> IDLE.
REQ-025 s_ready SHALL be 0 in KEY_LOAD, START, WAIT, TX; m_valid SHALL be 1 only in TX.
REQ-026 aes_key_o SHALL hold last fully received key; aes_block_o SHALL hold last received block; partial receptions update only shift registers, not these outputs.
REQ-027 aes_done_i outside WAIT SHALL be ignored.
REQ-028 busy_o SHALL equal (state != IDLE).
REQ-029 Byte counter SHALL wrap 15->0 on each completed 16-byte transfer.

Reset
REQ-030 rst_n=1 SHALL immediately force state IDLE, counters 0, key_valid_o=0, err_o=0, aes_key_load_o=0, aes_start_o=0, m_valid=0, m_data=0, aes_key_o=0, aes_block_o=0.
REQ-031 Reset mid-transfer SHALL abandon it; no strobe or output byte SHALL follow reset release without a new command.
REQ-032 s_ready SHALL be 0 while rst_n=1 and 1 on first cycle after release.

Configuration
REQ-033 Macro AES_CTRL_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without aes_done_i sets err_o, returns to IDLE, no TX.
REQ-034 AES_CTRL_TIMEOUT_EN undefined: WAIT waits indefinitely for aes_done_i; no timeout counter synthesized; TIMEOUT_CYCLES unused.

Verification
REQ-035 0x01 + key 00 01 .. 0f -> single-cycle aes_key_load_o, aes_key_o=000102030405060708090a0b0c0d0e0f, key_valid_o=1.
REQ-036 Then 0x02 + 00 11 22 .. ff, core model done after 12 cycles returning FIPS-197 result -> m_data sequence 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, m_ready toggling randomly, no byte lost/duplicated.
REQ-037 After reset, 0x02 + 16 bytes -> no aes_start_o, err_o=1; then 0x00 -> err_o=0; opcode 0x7f -> err_o=1.
REQ-038 rst_n=1 after 7 key bytes -> key_valid_o=0, aes_key_o=0, s_ready=1 after release, next 0x01+16 bytes loads correctly.
REQ-039 With AES_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never responds -> err_o=1 exactly 16 cycles after aes_start_o, IDLE, m_valid stays 0.
REQ-040 aes_done_i pulsed in IDLE -> no state change, m_valid=0.
